fxp_div_seq: RTL
================

Name: fxp_div_seq

Overview:
- Sequential restoring divider. It is the inverse datapath of the PE's Booth multiplier (mult_booth).
- Inputs:
  - 32-bit two's-complement product-format dividend: 24 fractional bits.
  - 16-bit sign-magnitude Q3.12 divisor: bit15 is the sign, then 3 integer bits and 12 fractional bits.
- Output: a sign-magnitude Q3.12 quotient, so that P/B recovers A for any product P = A*B from mult_booth.
- Used for normalisation and scaling in the PE post-processing path.
- Uses valid/ready handshakes on both input and output.

Parameters:
- DATA_W, 16, operand/quotient width (sign-magnitude, bit DATA_W-1 is the sign).
- PROD_W, 32, dividend width (two's complement); must equal 2*DATA_W.
- FRAC_W, 12, fractional bits of the operand format (dividend has 2*FRAC_W).

Ports:
- clk        input   1        clock, rising edge
- rst        input   1        asynchronous, active-high reset
- in_valid   input   1        dividend/divisor valid
- in_ready   output  1        block can accept operands
- dividend   input   PROD_W   two's-complement dividend
- divisor    input   DATA_W   sign-magnitude divisor
- out_valid  output  1        result valid
- out_ready  input   1        consumer accepts result
- quotient   output  DATA_W   sign-magnitude Q3.12 quotient
- ovf        output  1        quotient saturated (magnitude > 2^(DATA_W-1)-1, or divide by zero)
- dbz        output  1        divisor magnitude was zero

Behaviour:

Reset and clocking:
- One clock domain, clk.
- rst is asynchronous and active-high.
- rst forces state IDLE, out_valid=0, quotient=0, ovf=0, dbz=0, and clears the iteration counter and working registers.
- rst asserted mid-CALC or mid-DONE aborts the operation; the result is discarded and never presented.

States:
- IDLE:
  - in_ready=1, which is combinational from state (also 1 while rst is high; inputs are ignored under reset).
  - On in_valid&in_ready, register: sign_q = dividend[PROD_W-1] ^ divisor[DATA_W-1]; |dividend| (PROD_W-bit unsigned, so -2^31 gives 0x80000000); |divisor| = divisor[DATA_W-2:0].
  - If |divisor|==0, go to DONE with quotient = {sign_q, all-ones magnitude}, ovf=1, dbz=1. Latency is 1 cycle.
  - Otherwise go to CALC with counter = PROD_W-1.
- CALC:
  - One restoring step per cycle, MSB first:
    - rem = {rem, next dividend bit};
    - if rem >= |divisor|, then rem -= |divisor| and the quotient bit = 1.
  - The counter decrements each cycle. After PROD_W iterations (counter wrap from 0), go to DONE.
  - Total latency from the accept edge to out_valid high is PROD_W+1 = 33 edges.
  - in_ready=0 throughout CALC.
- DONE:
  - out_valid=1. quotient, ovf and dbz are registered and held stable until out_valid&out_ready.
  - On that handshake, go to IDLE. There is no same-cycle re-accept, because in_ready=0 in DONE.

Arithmetic rules:
- The integer quotient |P|/|B| is directly Q3.12; no extra shift is needed.
- Truncation is toward zero; no remainder is output.
- Overflow: if any quotient bit at index >= DATA_W-1 is set, the magnitude saturates to 2^(DATA_W-1)-1 (0x7FFF) and ovf=1.
- A zero-magnitude result forces sign=0 (no negative zero). The saturated result keeps sign_q.

Decomposition:
- Package fxp_div_pkg holds: the DATA_W/PROD_W/FRAC_W defaults, the state enum {IDLE, CALC, DONE}, the saturation constant MAG_MAX = 2^(DATA_W-1)-1, and the counter width clog2(PROD_W).
- One natural sub-module: fxp_div_step.
  - Combinational single restoring step.
  - Inputs: rem, next bit, divisor. Outputs: rem_next, q_bit.
  - The top module holds the FSM, counter, sign/magnitude conversion, saturation and handshake.

Test Plan:
- dividend=0x06F90000, divisor=0x2300, in_valid pulse:
  - in_ready drops the next cycle;
  - out_valid rises exactly 33 edges after accept;
  - quotient=0x3300, ovf=0, dbz=0.
- Sign handling:
  - dividend=0xF9070000, divisor=0xA300 -> 0x3300;
  - dividend=0xF9070000, divisor=0x2300 -> 0xB300;
  - dividend=0x00000000, divisor=0xA300 -> 0x0000 (no negative zero).
- Overflow: dividend=0x40000000, divisor=0x1000 -> quotient=0x7FFF, ovf=1, dbz=0. dividend=0x80000000, divisor=0x0001 -> quotient=0xFFFF, ovf=1.
- Divide by zero: dividend=0x06F90000, divisor=0x8000 -> out_valid 1 edge after accept, quotient=0xFFFF, ovf=1, dbz=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles after out_valid; quotient stays stable.
  - in_valid held high is not accepted until the cycle after the output handshake.
  - A second operand pair then completes correctly.
- Reset mid-CALC:
  - Assert rst 10 cycles into CALC, asynchronously between edges.
  - Outputs clear immediately and in_ready=1; no out_valid appears for the aborted operation.
  - A following op (0x06F90000/0x2300) yields 0x3300.

Source files
------------

// File: rtl/fxp_div_pkg.sv
// Shared constants and state encoding for the sequential fixed-point divider.
package fxp_div_pkg;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_PROD_W = 32;
   localparam int DEF_FRAC_W = 12;
   localparam int CNT_W      = $clog2(DEF_PROD_W);

   localparam logic [DEF_DATA_W-2:0] MAG_MAX = {(DEF_DATA_W-1){1'b1}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;
endpackage

// File: rtl/fxp_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract when it fits.
module fxp_div_step #(
   parameter int W = 15
) (
   input  logic [W-1:0] rem_i,
   input  logic         bit_i,
   input  logic [W-1:0] div_i,
   output logic [W-1:0] rem_o,
   output logic         q_bit_o
);
   logic [W:0] shifted;
   logic [W:0] diff;

   assign shifted = {rem_i, bit_i};
   assign diff    = shifted - {1'b0, div_i};
   assign q_bit_o = (shifted >= {1'b0, div_i});
   // When no subtraction happens the shifted value is below the divisor, so it fits in W bits.
   assign rem_o   = q_bit_o ? diff[W-1:0] : shifted[W-1:0];
endmodule

// File: rtl/fxp_div_seq.sv
// Sequential restoring divider: two's-complement product-format dividend over a
// sign-magnitude divisor, giving a saturated sign-magnitude quotient in operand format.
module fxp_div_seq
   import fxp_div_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int PROD_W = DEF_PROD_W,
   parameter int FRAC_W = DEF_FRAC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] quotient,
   output logic              ovf,
   output logic              dbz
);
   localparam int MAG_W = DATA_W - 1;
   localparam int CW    = $clog2(PROD_W);

   // Product fractional bits cancel against divisor fractional bits, so no shift is applied.
   if (PROD_W != 2 * DATA_W || FRAC_W >= DATA_W) begin : g_bad_params
      $error("fxp_div_seq: inconsistent width parameters");
   end

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sign_q, sign_d;
   logic [MAG_W-1:0]  div_q, div_d;
   logic [MAG_W-1:0]  rem_q, rem_d;
   logic [PROD_W-1:0] dvd_q, dvd_d;
   logic [PROD_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] quot_q, quot_d;
   logic              ovf_q, ovf_d;
   logic              dbz_q, dbz_d;

   logic [MAG_W-1:0]  step_rem;
   logic              step_bit;
   logic [PROD_W-1:0] quo_full;
   logic              sat;
   logic [MAG_W-1:0]  mag_res;
   logic [PROD_W-1:0] dvd_abs;

   fxp_div_step #(.W(MAG_W)) u_step (
      .rem_i   (rem_q),
      .bit_i   (dvd_q[PROD_W-1]),
      .div_i   (div_q),
      .rem_o   (step_rem),
      .q_bit_o (step_bit)
   );

   assign quo_full = {quo_q[PROD_W-2:0], step_bit};
   assign sat      = |quo_full[PROD_W-1:MAG_W];
   assign mag_res  = sat ? {MAG_W{1'b1}} : quo_full[MAG_W-1:0];
   assign dvd_abs  = dividend[PROD_W-1] ? (~dividend + {{(PROD_W-1){1'b0}}, 1'b1}) : dividend;

   assign quotient = quot_q;
   assign ovf      = ovf_q;
   assign dbz      = dbz_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sign_d    = sign_q;
      div_d     = div_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      quo_d     = quo_q;
      quot_d    = quot_q;
      ovf_d     = ovf_q;
      dbz_d     = dbz_q;
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d = dividend[PROD_W-1] ^ divisor[DATA_W-1];
               div_d  = divisor[MAG_W-1:0];
               dvd_d  = dvd_abs;
               rem_d  = '0;
               quo_d  = '0;
               cnt_d  = CW'(PROD_W - 1);
               if (divisor[MAG_W-1:0] == '0) begin
                  state_d = DONE;
                  quot_d  = {sign_d, {MAG_W{1'b1}}};
                  ovf_d   = 1'b1;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = step_rem;
            dvd_d = {dvd_q[PROD_W-2:0], 1'b0};
            quo_d = quo_full;
            cnt_d = cnt_q - 1'b1;
            // Last step: saturate and fold the sign straight into the output registers.
            if (cnt_q == '0) begin
               state_d = DONE;
               quot_d  = {sign_q & (mag_res != '0), mag_res};
               ovf_d   = sat;
               dbz_d   = 1'b0;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         div_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         quo_q   <= '0;
         quot_q  <= '0;
         ovf_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         quo_q   <= quo_d;
         quot_q  <= quot_d;
         ovf_q   <= ovf_d;
         dbz_q   <= dbz_d;
      end
   end
endmodule
